// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA timing decoder.
// The CRC constants exist only when VGA_FRAME_CRC_EN is defined.
package vga_pkg;
  localparam int H_TOTAL_DEF     = 800;
  localparam int V_TOTAL_DEF     = 525;
  localparam int H_ACTIVE_DEF    = 640;
  localparam int V_ACTIVE_DEF    = 480;
  localparam int LOCK_FRAMES_DEF = 2;

`ifdef VGA_FRAME_CRC_EN
  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;
`endif

  typedef logic [9:0] coord_t;

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} vtd_state_t;

  function automatic coord_t sat_inc(input coord_t v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction
endpackage

// File: rtl/vtd_crc16.sv
// CRC-16-CCITT next-state function consuming 12 data bits per step, MSB first.
// Present only in the VGA_FRAME_CRC_EN build.
`ifdef VGA_FRAME_CRC_EN
module vtd_crc16
  import vga_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [11:0] data,
  output logic [15:0] crc_out
);
  logic [15:0] c;

  always_comb begin
    c = crc_in;
    for (int i = 11; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ CRC_POLY;
      else                 c = {c[14:0], 1'b0};
    end
    crc_out = c;
  end
endmodule
`endif

// File: rtl/vga_timing_decoder.sv
// Recovers pixel coordinates, line/frame strobes and lock status from VGA hs/vs/blank.
// Defining VGA_FRAME_CRC_EN adds rgb_in/frame_crc and a per-frame CRC-16 of active pixels.
module vga_timing_decoder
  import vga_pkg::*;
#(
  parameter int H_TOTAL     = H_TOTAL_DEF,
  parameter int V_TOTAL     = V_TOTAL_DEF,
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int LOCK_FRAMES = LOCK_FRAMES_DEF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        pixel_clk,
  input  logic        hs,
  input  logic        vs,
  input  logic        blank,
`ifdef VGA_FRAME_CRC_EN
  input  logic [11:0] rgb_in,
  output logic [15:0] frame_crc,
`endif
  output logic [9:0]  RecX,
  output logic [9:0]  RecY,
  output logic        de,
  output logic        line_start,
  output logic        frame_start,
  output logic        locked,
  output logic        sync_err,
  output logic [9:0]  h_len,
  output logic [9:0]  v_len
);
  vtd_state_t state_q, state_d;
  logic       pix_clk_q, pix_clk_d;
  logic       hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
  coord_t     h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  coord_t     h_len_q, h_len_d, v_len_q, v_len_d;
  coord_t     rec_x_q, rec_x_d, rec_y_q, rec_y_d;
  logic       line_act_q, line_act_d, frame_act_q, frame_act_d;
  logic       frame_ok_q, frame_ok_d;
  logic [3:0] good_cnt_q, good_cnt_d;
  logic       de_q, de_d, line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d, sync_err_q, sync_err_d;

  logic       tick, hs_fall, vs_fall, blank_rise, is_locked;
  logic       bad_line, frame_good, de_now, line_act_eff, frame_act_eff;
  coord_t     h_len_new, v_len_new;

  always_comb begin
    tick       = pixel_clk & ~pix_clk_q;
    hs_fall    = tick & hs_q & ~hs;
    vs_fall    = tick & vs_q & ~vs;
    blank_rise = tick & ~blank_q & blank;
    is_locked  = (state_q == LOCKED);

    // A line ending on the same tick as vs_fall still belongs to the old frame.
    h_len_new  = sat_inc(h_cnt_q);
    v_len_new  = hs_fall ? sat_inc(v_cnt_q) : v_cnt_q;
    bad_line   = hs_fall & (h_len_new != coord_t'(H_TOTAL));
    frame_good = frame_ok_q & ~bad_line & (v_len_new == coord_t'(V_TOTAL));

    pix_clk_d     = pixel_clk;
    hs_d          = hs_q;
    vs_d          = vs_q;
    blank_d       = blank_q;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    h_len_d       = h_len_q;
    v_len_d       = v_len_q;
    rec_x_d       = rec_x_q;
    rec_y_d       = rec_y_q;
    state_d       = state_q;
    good_cnt_d    = good_cnt_q;
    frame_ok_d    = frame_ok_q;
    de_d          = de_q;
    line_start_d  = hs_fall & is_locked;
    frame_start_d = vs_fall & is_locked;
    sync_err_d    = 1'b0;

    line_act_eff  = line_act_q & ~hs_fall;
    frame_act_eff = frame_act_q & ~vs_fall;
    line_act_d    = line_act_q;
    frame_act_d   = frame_act_q;

    if (tick) begin
      hs_d        = hs;
      vs_d        = vs;
      blank_d     = blank;
      h_cnt_d     = hs_fall ? '0 : sat_inc(h_cnt_q);
      line_act_d  = line_act_eff | blank_rise;
      frame_act_d = frame_act_eff | blank_rise;
      if (hs_fall) h_len_d = h_len_new;
      if (vs_fall) begin
        v_cnt_d = '0;
        v_len_d = v_len_new;
      end else if (hs_fall) begin
        v_cnt_d = sat_inc(v_cnt_q);
      end

      // The first active pixel of a line holds the 0 loaded at hs_fall.
      if (hs_fall)
        rec_x_d = '0;
      else if (blank && blank_q && rec_x_q != coord_t'(H_ACTIVE - 1))
        rec_x_d = rec_x_q + 10'd1;

      if (blank_rise && !line_act_eff && frame_act_eff && rec_y_q != coord_t'(V_ACTIVE - 1))
        rec_y_d = rec_y_q + 10'd1;
      else if (vs_fall)
        rec_y_d = '0;
    end

    case (state_q)
      SEARCH: begin
        if (vs_fall) begin
          state_d    = MEASURE;
          good_cnt_d = '0;
          frame_ok_d = 1'b1;
        end
      end
      MEASURE: begin
        if (vs_fall) begin
          frame_ok_d = 1'b1;
          if (frame_good) begin
            good_cnt_d = good_cnt_q + 4'd1;
            if (good_cnt_q + 4'd1 == 4'(LOCK_FRAMES)) state_d = LOCKED;
          end else begin
            good_cnt_d = '0;
          end
        end else if (bad_line) begin
          frame_ok_d = 1'b0;
        end
      end
      LOCKED: begin
        if (bad_line || (vs_fall && !frame_good)) begin
          sync_err_d = 1'b1;
          state_d    = MEASURE;
          good_cnt_d = '0;
          frame_ok_d = vs_fall;
        end else if (vs_fall) begin
          frame_ok_d = 1'b1;
        end
      end
      default: state_d = SEARCH;
    endcase

    de_now = tick & (state_d == LOCKED) & blank;
    if (tick) de_d = de_now;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= SEARCH;
      pix_clk_q     <= 1'b0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_q       <= 1'b0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      h_len_q       <= '0;
      v_len_q       <= '0;
      rec_x_q       <= '0;
      rec_y_q       <= '0;
      line_act_q    <= 1'b0;
      frame_act_q   <= 1'b0;
      frame_ok_q    <= 1'b0;
      good_cnt_q    <= '0;
      de_q          <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pix_clk_q     <= pix_clk_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_q       <= blank_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      h_len_q       <= h_len_d;
      v_len_q       <= v_len_d;
      rec_x_q       <= rec_x_d;
      rec_y_q       <= rec_y_d;
      line_act_q    <= line_act_d;
      frame_act_q   <= frame_act_d;
      frame_ok_q    <= frame_ok_d;
      good_cnt_q    <= good_cnt_d;
      de_q          <= de_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign RecX        = rec_x_q;
  assign RecY        = rec_y_q;
  assign de          = de_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign locked      = (state_q == LOCKED);
  assign sync_err    = sync_err_q;
  assign h_len       = h_len_q;
  assign v_len       = v_len_q;

`ifdef VGA_FRAME_CRC_EN
  logic [15:0] crc_q, crc_d, crc_step, frame_crc_q, frame_crc_d;

  vtd_crc16 u_crc (
    .crc_in  (crc_q),
    .data    (rgb_in),
    .crc_out (crc_step)
  );

  // The running CRC is published and restarted at every frame boundary.
  always_comb begin
    crc_d       = crc_q;
    frame_crc_d = frame_crc_q;
    if (vs_fall) begin
      frame_crc_d = crc_q;
      crc_d       = CRC_INIT;
    end else if (de_now) begin
      crc_d = crc_step;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      crc_q       <= CRC_INIT;
      frame_crc_q <= '0;
    end else begin
      crc_q       <= crc_d;
      frame_crc_q <= frame_crc_d;
    end
  end

  assign frame_crc = frame_crc_q;
`endif
endmodule

// File: tb/tb_vga_timing_decoder.sv
// Directed bench for vga_timing_decoder on a scaled-down 20x10 raster (10x6 active).
// Frame CRC checks are included when VGA_FRAME_CRC_EN is defined.
`timescale 1ns/1ps
module tb_vga_timing_decoder;
  localparam int HT  = 20;
  localparam int VT  = 10;
  localparam int HA  = 10;
  localparam int VA  = 6;
  localparam int HSW = 3;
  localparam int HB  = 5;
  localparam int VSW = 2;
  localparam int VB  = 3;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       pixel_clk = 1'b0;
  logic       hs = 1'b1;
  logic       vs = 1'b1;
  logic       blank = 1'b0;
  logic [9:0] RecX, RecY, h_len, v_len;
  logic       de, line_start, frame_start, locked, sync_err;
`ifdef VGA_FRAME_CRC_EN
  logic [11:0] rgb_in = 12'h000;
  logic [15:0] frame_crc;
  logic [15:0] crcModel = 16'hFFFF;
  logic [15:0] crcA, crcB;
`endif

  int testsRun = 0;
  int testsFailed = 0;
  int deTicks = 0, rxBad = 0, ryBad = 0;
  int lineStarts = 0, frameStarts = 0, syncErrs = 0;
  int expX = 0, expY = 0;

  always #10 Clk = ~Clk;

  vga_timing_decoder #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA), .LOCK_FRAMES(2)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .pixel_clk   (pixel_clk),
    .hs          (hs),
    .vs          (vs),
    .blank       (blank),
`ifdef VGA_FRAME_CRC_EN
    .rgb_in      (rgb_in),
    .frame_crc   (frame_crc),
`endif
    .RecX        (RecX),
    .RecY        (RecY),
    .de          (de),
    .line_start  (line_start),
    .frame_start (frame_start),
    .locked      (locked),
    .sync_err    (sync_err),
    .h_len       (h_len),
    .v_len       (v_len)
  );

`ifdef VGA_FRAME_CRC_EN
  function automatic logic [15:0] crcStep(input logic [15:0] c, input logic [11:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 11; i >= 0; i--) begin
      if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction
`endif

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One pixel period: tick edge, then outputs sampled on the following falling Clk edge.
  task automatic applyStimulus(input logic h, input logic v, input logic b);
    @(negedge Clk);
    hs = h;
    vs = v;
    blank = b;
    pixel_clk = 1'b1;
    @(negedge Clk);
    pixel_clk = 1'b0;
    if (de === 1'b1) begin
      deTicks++;
      if (RecX !== 10'(expX)) rxBad++;
      if (RecY !== 10'(expY)) ryBad++;
`ifdef VGA_FRAME_CRC_EN
      crcModel = crcStep(crcModel, rgb_in);
`endif
    end
    if (line_start === 1'b1) lineStarts++;
    if (frame_start === 1'b1) frameStarts++;
    if (sync_err === 1'b1) syncErrs++;
  endtask

  task automatic sendTicks(input int l, input int t0, input int t1);
    for (int t = t0; t < t1; t++) begin
      expX = t - HB;
      expY = l - VB;
      applyStimulus(t >= HSW, l >= VSW, (l >= VB) && (l < VB + VA) && (t >= HB) && (t < HB + HA));
    end
  endtask

  task automatic sendLines(input int l0, input int l1);
    for (int l = l0; l < l1; l++) sendTicks(l, 0, HT);
  endtask

  initial begin
    repeat (3) @(negedge Clk);
    checkOutput("rst_coords", 32'({RecX, RecY, h_len, v_len}), 0);
    checkOutput("rst_flags", 32'({de, line_start, frame_start, locked, sync_err}), 0);
    Reset = 1'b0;

    // Acquisition: lock arrives at the third vs falling edge.
    sendLines(0, VT);
    sendLines(0, VT);
    checkOutput("pre_lock", 32'(locked), 0);
    checkOutput("h_len_std", 32'(h_len), HT);
    checkOutput("v_len_std", 32'(v_len), VT);
    sendTicks(0, 0, 1);
    checkOutput("lock_rise", 32'(locked), 1);
    checkOutput("fs_at_lock", 32'(frame_start), 0);
    checkOutput("no_err_acq", syncErrs, 0);

    // One fully locked frame.
    deTicks = 0; rxBad = 0; ryBad = 0; lineStarts = 0;
    sendTicks(0, 1, HT);
    sendLines(1, VT);
    checkOutput("de_ticks", deTicks, HA * VA);
    checkOutput("recx_seq", rxBad, 0);
    checkOutput("recy_seq", ryBad, 0);
    checkOutput("recy_last", 32'(RecY), VA - 1);
    checkOutput("line_starts", lineStarts, VT - 1);
    sendTicks(0, 0, 1);
    checkOutput("fs_pulse", 32'(frame_start), 1);
    checkOutput("ls_pulse", 32'(line_start), 1);
    @(negedge Clk);
    checkOutput("fs_width", 32'(frame_start), 0);

    // A 19-tick line drops lock; two good frames re-acquire it.
    syncErrs = 0;
    sendTicks(0, 1, HT);
    sendLines(1, 4);
    sendTicks(4, 0, HT - 1);
    sendTicks(5, 0, 1);
    checkOutput("short_err", 32'(sync_err), 1);
    checkOutput("short_unlock", 32'(locked), 0);
    checkOutput("short_hlen", 32'(h_len), HT - 1);
    @(negedge Clk);
    checkOutput("err_width", 32'(sync_err), 0);
    sendTicks(5, 1, HT);
    sendLines(6, VT);
    deTicks = 0;
    sendLines(0, VT);
    sendLines(0, VT);
    checkOutput("relock_wait", 32'(locked), 0);
    checkOutput("de_gated", deTicks, 0);
    sendTicks(0, 0, 1);
    checkOutput("relock", 32'(locked), 1);
    checkOutput("err_count", syncErrs, 1);

    // pixel_clk stalled mid-line.
    sendTicks(0, 1, HT);
    sendLines(1, 4);
    sendTicks(4, 0, 10);
    checkOutput("stall_pre", 32'(RecX), 4);
    repeat (100) @(negedge Clk);
    checkOutput("stall_hold", 32'(RecX), 4);
    checkOutput("stall_lock", 32'(locked), 1);
    sendTicks(4, 10, HT);
    sendTicks(5, 0, 1);
    checkOutput("stall_hlen", 32'(h_len), HT);
    sendTicks(5, 1, HT);
    sendLines(6, VT);
    sendTicks(0, 0, 1);
    checkOutput("stall_vlen", 32'(v_len), VT);
    checkOutput("stall_kept", 32'(locked), 1);

    // Reset mid-line of a locked frame.
    sendTicks(0, 1, HT);
    sendLines(1, 5);
    sendTicks(5, 0, 8);
    Reset = 1'b1;
    @(negedge Clk);
    checkOutput("mid_rst_coords", 32'({RecX, RecY, h_len, v_len}), 0);
    checkOutput("mid_rst_flags", 32'({de, line_start, frame_start, locked, sync_err}), 0);
    Reset = 1'b0;
    frameStarts = 0;
    sendTicks(5, 8, HT);
    sendLines(6, VT);
    sendLines(0, VT);
    sendLines(0, VT);
    checkOutput("rst_relock_wait", 32'(locked), 0);
    sendTicks(0, 0, 1);
    checkOutput("rst_relock", 32'(locked), 1);
    checkOutput("rst_no_fs", frameStarts, 0);

`ifdef VGA_FRAME_CRC_EN
    rgb_in = 12'hF00;
    crcModel = 16'hFFFF;
    sendTicks(0, 1, HT);
    sendLines(1, VT);
    sendTicks(0, 0, 1);
    checkOutput("crc_f00", 32'(frame_crc), 32'(crcModel));
    crcA = crcModel;
    crcModel = 16'hFFFF;
    rgb_in = 12'h000;
    sendTicks(0, 1, HT);
    sendLines(1, VT);
    sendTicks(0, 0, 1);
    checkOutput("crc_zero", 32'(frame_crc), 32'(crcModel));
    checkOutput("crc_differs", 32'(frame_crc !== crcA), 1);
    crcB = crcModel;
    crcModel = 16'hFFFF;
    sendTicks(0, 1, HT);
    sendLines(1, VT);
    sendTicks(0, 0, 1);
    checkOutput("crc_stable", 32'(frame_crc), 32'(crcB));
`endif

    // Overlong line: h_len saturates and lock drops.
    sendTicks(0, 1, HT);
    sendTicks(1, 0, 1100);
    sendTicks(2, 0, 1);
    checkOutput("h_len_sat", 32'(h_len), 1023);
    checkOutput("long_err", 32'(sync_err), 1);
    checkOutput("long_unlock", 32'(locked), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
